// File: rtl/sobel_magnitude_pipe.sv
// Three-stage Sobel edge-magnitude pipeline with optional binarisation and a
// per-frame output pixel counter.
// Stage 1: Gx/Gy gradients. Stage 2: |Gx|+|Gy|. Stage 3: output pixel.
// All outputs are driven from registers only.
module sobel_magnitude_pipe #(
  parameter int unsigned IMG_WIDTH    = 256,
  parameter int unsigned FRAME_PIXELS = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  Z1,
  input  logic [7:0]  Z2,
  input  logic [7:0]  Z3,
  input  logic [7:0]  Z4,
  input  logic [7:0]  Z5,
  input  logic [7:0]  Z6,
  input  logic [7:0]  Z7,
  input  logic [7:0]  Z8,
  input  logic [7:0]  Z9,
  input  logic        valid_in,
  input  logic        black_in,
  input  logic        thresh_en,
  input  logic [7:0]  threshold,
  output logic [7:0]  pixel_out,
  output logic        pixel_valid,
  output logic        frame_done,
  output logic [16:0] pix_count
);

  // The counter is 17 bits wide, so a frame cannot exceed 2^17 pixels.
  if (IMG_WIDTH < 3 || FRAME_PIXELS < 1 || FRAME_PIXELS > 131072) begin : g_param_check
    $error("sobel_magnitude_pipe: unsupported IMG_WIDTH/FRAME_PIXELS");
  end

  localparam logic [16:0] LastIdx = 17'(FRAME_PIXELS - 1);

  // Stage 1 state
  logic        r_s1_valid;
  logic        r_s1_black;
  logic [10:0] r_gx;
  logic [10:0] r_gy;
  // Stage 2 state
  logic        r_s2_valid;
  logic        r_s2_black;
  logic [10:0] r_mag;
  // Stage 3 / output state
  logic        r_out_valid;
  logic [7:0]  r_pix;
  logic [16:0] r_pix_count;

  logic [10:0] w_gx_pos;
  logic [10:0] w_gx_neg;
  logic [10:0] w_gy_pos;
  logic [10:0] w_gy_neg;
  logic [10:0] w_gx;
  logic [10:0] w_gy;
  logic [10:0] w_abs_gx;
  logic [10:0] w_abs_gy;
  logic [10:0] w_mag;
  logic [7:0]  w_sat;
  logic [7:0]  w_pix;
  logic        w_s1_take;
  logic        w_s2_take;
  logic        w_last;

  // Gradient kernels; partial sums are at most 1020 so the 11-bit difference
  // is an exact two's-complement result.
  always_comb begin
    w_gx_pos  = {3'b0, Z3} + {2'b0, Z6, 1'b0} + {3'b0, Z9};
    w_gx_neg  = {3'b0, Z1} + {2'b0, Z4, 1'b0} + {3'b0, Z7};
    w_gy_pos  = {3'b0, Z7} + {2'b0, Z8, 1'b0} + {3'b0, Z9};
    w_gy_neg  = {3'b0, Z1} + {2'b0, Z2, 1'b0} + {3'b0, Z3};
    w_gx      = w_gx_pos - w_gx_neg;
    w_gy      = w_gy_pos - w_gy_neg;
    w_s1_take = valid_in | black_in;
  end

  // Stage 1 register: flags follow inputs every cycle, data only on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_black <= 1'b0;
      r_gx       <= '0;
      r_gy       <= '0;
    end else begin
      r_s1_valid <= valid_in;
      r_s1_black <= black_in;
      if (w_s1_take) begin
        r_gx <= w_gx;
        r_gy <= w_gy;
      end
    end
  end

  // Absolute values and their sum; max 1020 + 1020 = 2040 fits in 11 bits.
  always_comb begin
    w_abs_gx  = r_gx[10] ? (~r_gx + 11'd1) : r_gx;
    w_abs_gy  = r_gy[10] ? (~r_gy + 11'd1) : r_gy;
    w_mag     = w_abs_gx + w_abs_gy;
    w_s2_take = r_s1_valid | r_s1_black;
  end

  // Stage 2 register: magnitude.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_black <= 1'b0;
      r_mag      <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_black <= r_s1_black;
      if (w_s2_take) begin
        r_mag <= w_mag;
      end
    end
  end

  // Output pixel selection; black wins, then binarisation, then saturation.
  always_comb begin
    w_sat = (r_mag > 11'd255) ? 8'hFF : r_mag[7:0];
    w_pix = w_sat;
    if (r_s2_black) begin
      w_pix = 8'h00;
    end else if (thresh_en) begin
      w_pix = (w_sat >= threshold) ? 8'hFF : 8'h00;
    end
  end

  // Stage 3 register: one output per sample carrying either flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_pix       <= '0;
    end else begin
      r_out_valid <= r_s2_valid | r_s2_black;
      if (r_s2_valid | r_s2_black) begin
        r_pix <= w_pix;
      end
    end
  end

  // Last pixel of the frame is flagged while it is on the output.
  always_comb begin
    w_last = r_out_valid && (r_pix_count == LastIdx);
  end

  // Frame pixel counter; wraps after the last pixel of a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix_count <= '0;
    end else if (r_out_valid) begin
      r_pix_count <= w_last ? 17'd0 : r_pix_count + 17'd1;
    end
  end

  assign pixel_out   = r_pix;
  assign pixel_valid = r_out_valid;
  assign frame_done  = w_last;
  assign pix_count   = r_pix_count;

endmodule

// File: tb/tb_sobel_magnitude_pipe.sv
// Self-checking bench for sobel_magnitude_pipe: directed windows plus random
// traffic, compared cycle by cycle against a history-based reference model.
module tb_sobel_magnitude_pipe;

  localparam int unsigned Fp   = 4;
  localparam int          Hist = 4096;

  logic        clk;
  logic        rst;
  logic [7:0]  win [9];
  logic        valid_in;
  logic        black_in;
  logic        thresh_en;
  logic [7:0]  threshold;
  logic [7:0]  pixel_out;
  logic        pixel_valid;
  logic        frame_done;
  logic [16:0] pix_count;

  sobel_magnitude_pipe #(
    .IMG_WIDTH    (256),
    .FRAME_PIXELS (Fp)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .Z1          (win[0]),
    .Z2          (win[1]),
    .Z3          (win[2]),
    .Z4          (win[3]),
    .Z5          (win[4]),
    .Z6          (win[5]),
    .Z7          (win[6]),
    .Z8          (win[7]),
    .Z9          (win[8]),
    .valid_in    (valid_in),
    .black_in    (black_in),
    .thresh_en   (thresh_en),
    .threshold   (threshold),
    .pixel_out   (pixel_out),
    .pixel_valid (pixel_valid),
    .frame_done  (frame_done),
    .pix_count   (pix_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-cycle record of what was presented on the inputs.
  int h_v   [Hist];
  int h_b   [Hist];
  int h_mag [Hist];
  int h_te  [Hist];
  int h_th  [Hist];

  int cyc;
  int flush;      // samples presented before this cycle were killed by reset
  int model_cnt;  // expected pix_count
  int n_checks;
  int n_errors;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic int window_mag();
    int z [9];
    int gx, gy;
    for (int i = 0; i < 9; i++) z[i] = int'(win[i]);
    gx = (z[2] + 2 * z[5] + z[8]) - (z[0] + 2 * z[3] + z[6]);
    gy = (z[6] + 2 * z[7] + z[8]) - (z[0] + 2 * z[1] + z[2]);
    return iabs(gx) + iabs(gy);
  endfunction

  // Compare outputs of cycle cyc with the sample presented 3 cycles earlier,
  // using the threshold settings present during the cycle before this one.
  task automatic check_cycle();
    int s, exp_v, exp_pix, sat;
    s = cyc - 3;
    exp_v = 0;
    if (s >= 0 && s >= flush) exp_v = (h_v[s] != 0 || h_b[s] != 0) ? 1 : 0;
    check_val("pixel_valid", int'(pixel_valid), exp_v);
    if (exp_v != 0) begin
      sat = (h_mag[s] > 255) ? 255 : h_mag[s];
      if (h_b[s] != 0)          exp_pix = 0;
      else if (h_te[cyc-1] != 0) exp_pix = (sat >= h_th[cyc-1]) ? 255 : 0;
      else                      exp_pix = sat;
      check_val("pixel_out", int'(pixel_out), exp_pix);
    end
    check_val("pix_count", int'(pix_count), model_cnt);
    check_val("frame_done", int'(frame_done),
              (exp_v != 0 && model_cnt == int'(Fp) - 1) ? 1 : 0);
    if (exp_v != 0) model_cnt = (model_cnt + 1) % int'(Fp);
  endtask

  task automatic record(input logic v, input logic b, input logic te, input logic [7:0] th);
    valid_in  = v;
    black_in  = b;
    thresh_en = te;
    threshold = th;
    h_v[cyc]   = int'(v);
    h_b[cyc]   = int'(b);
    h_te[cyc]  = int'(te);
    h_th[cyc]  = int'(th);
    h_mag[cyc] = window_mag();
  endtask

  task automatic drive(input logic v, input logic b, input logic te, input logic [7:0] th);
    record(v, b, te, th);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_cycle();
  endtask

  // One sample followed by idle cycles with the same threshold settings.
  task automatic drive_iso(input logic v, input logic b, input logic te, input logic [7:0] th);
    drive(v, b, te, th);
    repeat (3) drive(1'b0, 1'b0, te, th);
  endtask

  // One-cycle reset pulse starting just after an edge; v presents the current
  // window as a sample on that edge so it is in flight when reset hits.
  task automatic pulse_reset(input logic v);
    record(v, 1'b0, 1'b0, 8'd0);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    valid_in = 1'b0;
    flush    = cyc + 1;
    model_cnt = 0;
    @(negedge clk);
    cyc++;
    h_v[cyc] = 0;
    h_b[cyc] = 0;
    check_cycle();
    check_val("rst_pixel_out", int'(pixel_out), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    cyc++;
    check_cycle();
  endtask

  task automatic set_rows(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    for (int i = 0; i < 3; i++) begin
      win[i]     = a;
      win[i + 3] = b;
      win[i + 6] = c;
    end
  endtask

  task automatic set_random_win(input bool_small);
    int base;
    base = int'($urandom_range(0, 200));
    for (int i = 0; i < 9; i++) begin
      if (bool_small != 0) win[i] = 8'(base + int'($urandom_range(0, 40)));
      else                 win[i] = 8'($urandom_range(0, 255));
    end
  endtask

  initial begin
    cyc = 0; flush = 0; model_cnt = 0; n_checks = 0; n_errors = 0;
    for (int i = 0; i < Hist; i++) begin
      h_v[i] = 0; h_b[i] = 0; h_mag[i] = 0; h_te[i] = 0; h_th[i] = 0;
    end
    rst = 1'b1;
    valid_in = 1'b0; black_in = 1'b0; thresh_en = 1'b0; threshold = 8'd0;
    set_rows(8'd0, 8'd0, 8'd0);
    repeat (2) @(negedge clk);
    check_val("rst_pixel_out", int'(pixel_out), 0);
    check_val("rst_pixel_valid", int'(pixel_valid), 0);
    check_val("rst_frame_done", int'(frame_done), 0);
    check_val("rst_pix_count", int'(pix_count), 0);
    rst = 1'b0;

    // Uniform window gives zero gradient.
    set_rows(8'd50, 8'd50, 8'd50);
    drive_iso(1'b1, 1'b0, 1'b0, 8'd0);
    // Vertical ramp: magnitude 40, threshold boundary at 40/41.
    set_rows(8'd10, 8'd15, 8'd20);
    drive_iso(1'b1, 1'b0, 1'b0, 8'd0);
    drive_iso(1'b1, 1'b0, 1'b1, 8'd40);
    drive_iso(1'b1, 1'b0, 1'b1, 8'd41);
    // Strong vertical edge saturates; black overrides it.
    set_rows(8'd0, 8'd0, 8'd0);
    win[2] = 8'd100; win[5] = 8'd100; win[8] = 8'd100;
    drive_iso(1'b1, 1'b0, 1'b0, 8'd0);
    drive_iso(1'b1, 1'b1, 1'b0, 8'd0);
    drive_iso(1'b0, 1'b1, 1'b0, 8'd0);
    drive_iso(1'b1, 1'b0, 1'b1, 8'd255);

    // Ten back-to-back samples with the threshold toggling mid-stream.
    for (int i = 0; i < 10; i++) begin
      set_random_win(1);
      drive(1'b1, 1'b0, 1'(i % 2), 8'(60 + 10 * i));
    end
    // Alternating gaps.
    for (int i = 0; i < 10; i++) begin
      set_random_win(1);
      drive(1'(i % 2 == 0), 1'b0, 1'b0, 8'd0);
    end
    repeat (3) drive(1'b0, 1'b0, 1'b0, 8'd0);

    // Reset with three samples in flight: none may emerge.
    set_random_win(1);
    drive(1'b1, 1'b0, 1'b0, 8'd0);
    drive(1'b1, 1'b0, 1'b0, 8'd0);
    pulse_reset(1'b1);
    repeat (5) drive(1'b0, 1'b0, 1'b0, 8'd0);

    // Six samples across a frame boundary of four pixels.
    pulse_reset(1'b0);
    for (int i = 0; i < 6; i++) begin
      set_random_win(1);
      drive(1'b1, 1'b0, 1'b0, 8'd0);
    end
    repeat (4) drive(1'b0, 1'b0, 1'b0, 8'd0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic v, b, te;
      set_random_win(int'($urandom_range(0, 2)) != 0 ? 1 : 0);
      v  = ($urandom_range(0, 99) < 55);
      b  = ($urandom_range(0, 99) < 15);
      te = ($urandom_range(0, 99) < 40);
      drive(v, b, te, 8'($urandom_range(0, 255)));
    end
    repeat (4) drive(1'b0, 1'b0, 1'b0, 8'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
